// File: rtl/flicker_channel_pkg.sv
// Shared types and default parameters for the flicker-handshake byte transmitter.
package flicker_channel_pkg;

  localparam int unsigned DEF_DEPTH       = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_TIMEOUT     = 1048575;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } tx_state_e;

endpackage

// File: rtl/flicker_tx_fifo.sv
// Synchronous byte FIFO with registered occupancy; head is readable only after the push edge.
module flicker_tx_fifo
  import flicker_channel_pkg::*;
#(
  parameter int unsigned pDEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic [$clog2(pDEPTH):0]  count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(pDEPTH);

  logic [7:0]    mem_q [pDEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(pDEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/flicker_channel_tx.sv
// Byte transmitter: FIFO feeds a data bus qualified by a write-flicker toggle, acked by a peer toggle.
//   state    | meaning
//   IDLE     | waiting for a queued byte and a matching (in-sync) ack
//   SETUP    | byte on data_o, one cycle of setup before the toggle
//   WAIT_ACK | toggle issued, waiting for the peer to echo it
module flicker_channel_tx
  import flicker_channel_pkg::*;
#(
  parameter int unsigned pDEPTH       = DEF_DEPTH,
  parameter int unsigned pSYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned pTIMEOUT     = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic [7:0]               in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [7:0]               data_o,
  output logic                     write_flicker_o,
  input  logic                     read_flicker_i,
  input  logic                     clear_i,
  output logic                     busy_o,
  output logic [$clog2(pDEPTH):0]  fifo_count_o,
  output logic                     timeout_o,
  output logic                     desync_o
);

  localparam int unsigned TW = (pTIMEOUT > 0) ? $clog2(pTIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_MAX  = TW'(pTIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'((pTIMEOUT > 0) ? pTIMEOUT - 1 : 0);

  tx_state_e               state_q, state_d;
  logic [pSYNC_STAGES-1:0] sync_q;
  logic                    ack_s;
  logic [7:0]              data_q, data_d;
  logic                    wf_q, wf_d;
  logic [TW-1:0]           to_cnt_q, to_cnt_d;
  logic                    timeout_q, timeout_d, timeout_set;
  logic                    pop;
  logic [7:0]              fifo_head;
  logic                    fifo_full, fifo_empty;

  flicker_tx_fifo #(.pDEPTH(pDEPTH)) u_fifo (
    .clk     (clk),
    .reset_i (reset_i),
    .push_i  (in_valid_i),
    .data_i  (in_data_i),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ack_s = sync_q[pSYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= read_flicker_i;
      for (int i = 1; i < pSYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    wf_d        = wf_q;
    to_cnt_d    = to_cnt_q;
    pop         = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && (ack_s == wf_q)) begin
          pop     = 1'b1;
          data_d  = fifo_head;
          state_d = SETUP;
        end
      end
      SETUP: begin
        wf_d     = ~wf_q;
        to_cnt_d = '0;
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + TW'(1);
        // Fires once, on the cycle the count reaches the limit; saturation prevents re-arming.
        if ((pTIMEOUT > 0) && (to_cnt_q == TO_LAST)) timeout_set = 1'b1;
        if (ack_s == wf_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout_set)  timeout_d = 1'b1;
    else if (clear_i) timeout_d = 1'b0;
    else              timeout_d = timeout_q;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q   <= IDLE;
      data_q    <= '0;
      wf_q      <= 1'b0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      wf_q      <= wf_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign in_ready_o      = !fifo_full;
  assign data_o          = data_q;
  assign write_flicker_o = wf_q;
  assign busy_o          = (state_q != IDLE);
  assign timeout_o       = timeout_q;
  assign desync_o        = (state_q == IDLE) && (ack_s != wf_q);

endmodule

// File: tb/tb_flicker_channel_tx.sv
// Self-checking bench: cycle vector table, directed corner sequences, and a randomized peer with an in-order scoreboard.
module tb_flicker_channel_tx;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] in_data_i = '0;
  logic       in_valid_i = 1'b0;
  logic       read_flicker_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       in_ready_o, write_flicker_o, busy_o, timeout_o, desync_o;
  logic [7:0] data_o;
  logic [3:0] fifo_count_o;

  always #5 clk = ~clk;

  flicker_channel_tx #(.pDEPTH(DEPTH), .pSYNC_STAGES(SYNC), .pTIMEOUT(TMO)) dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .in_data_i       (in_data_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .data_o          (data_o),
    .write_flicker_o (write_flicker_o),
    .read_flicker_i  (read_flicker_i),
    .clear_i         (clear_i),
    .busy_o          (busy_o),
    .fifo_count_o    (fifo_count_o),
    .timeout_o       (timeout_o),
    .desync_o        (desync_o)
  );

  int total = 0;
  int bad   = 0;
  int toggles = 0;
  logic [7:0] delivered[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] din;
    logic       rfl;
    logic       clr;
    logic [7:0] e_data;
    logic       e_wf;
    logic       e_busy;
    logic [3:0] e_cnt;
    logic       e_rdy;
    logic       e_des;
    logic       e_to;
  } vec_t;

  vec_t vt[12];

  // Records every toggle of write_flicker_o outside reset, with the byte on the bus at that moment.
  initial begin : monitor
    logic prev_wf;
    logic r;
    prev_wf = 1'b0;
    forever begin
      @(posedge clk);
      r = reset_i;
      #2;
      if (write_flicker_o !== prev_wf) begin
        if (r === 1'b0) begin
          toggles++;
          delivered.push_back(data_o);
        end
        prev_wf = write_flicker_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic rfl);
    reset_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; clear_i = 1'b0; read_flicker_i = rfl;
    tick(); tick();
    reset_i = 1'b0;
    toggles = 0; delivered.delete(); exp_q.delete();
  endtask

  // Random producer and peer; appends accepted bytes to exp_q and runs until everything is acked.
  task automatic run_random(input int n, input int max_cycles);
    int   sent = 0;
    int   guard = 0;
    int   dly = 0;
    logic acc;
    while (guard < max_cycles &&
           !(sent >= n && delivered.size() == exp_q.size() && busy_o === 1'b0)) begin
      if (sent < n && $urandom_range(0, 3) != 0) begin
        in_valid_i = 1'b1;
        in_data_i  = 8'($urandom);
      end else begin
        in_valid_i = 1'b0;
      end
      if (write_flicker_o !== read_flicker_i) begin
        if (dly == 0) read_flicker_i = write_flicker_o;
        else dly--;
      end else begin
        dly = $urandom_range(0, 4);
      end
      acc = in_valid_i && in_ready_o;
      tick();
      guard++;
      if (acc) begin
        exp_q.push_back(in_data_i);
        sent++;
      end
    end
    in_valid_i = 1'b0;
    check("drain_in_budget", 32'(guard < max_cycles), 32'd1);
  endtask

  task automatic check_order(input string tag);
    check({tag, "_n"}, delivered.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < delivered.size(); i++)
      check($sformatf("%s_b%0d", tag, i), delivered[i], exp_q[i]);
    check({tag, "_toggles"}, toggles, exp_q.size());
    check({tag, "_empty"}, fifo_count_o, 0);
  endtask

  initial begin
    // rst vld din rfl clr | data wf busy cnt rdy des to
    vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      reset_i = vt[i].rst; in_valid_i = vt[i].vld; in_data_i = vt[i].din;
      read_flicker_i = vt[i].rfl; clear_i = vt[i].clr;
      tick();
      check($sformatf("v%0d_data", i),   data_o,          vt[i].e_data);
      check($sformatf("v%0d_wf", i),     write_flicker_o, vt[i].e_wf);
      check($sformatf("v%0d_busy", i),   busy_o,          vt[i].e_busy);
      check($sformatf("v%0d_count", i),  fifo_count_o,    vt[i].e_cnt);
      check($sformatf("v%0d_ready", i),  in_ready_o,      vt[i].e_rdy);
      check($sformatf("v%0d_desync", i), desync_o,        vt[i].e_des);
      check($sformatf("v%0d_timeout", i), timeout_o,      vt[i].e_to);
    end
    in_valid_i = 1'b0;

    // Burst of nine with no acks: the first byte pops at once, the other eight fill the FIFO.
    do_reset(1'b0);
    in_valid_i = 1'b1;
    for (int b = 0; b < 9; b++) begin
      in_data_i = 8'(b);
      for (int g = 0; g < 20 && in_ready_o !== 1'b1; g++) tick();
      exp_q.push_back(8'(b));
      tick();
    end
    check("burst_count", fifo_count_o, 8);
    check("burst_ready", in_ready_o, 0);
    in_data_i = 8'hFF;
    tick(); tick();
    check("burst_full_hold", fifo_count_o, 8);
    in_valid_i = 1'b0;
    run_random(0, 500);
    check_order("burst");

    // Push on the pop edge at occupancy 3, then continue to 20 bytes so the pointers wrap.
    do_reset(1'b0);
    in_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data_i = 8'(8'h10 + i);
      exp_q.push_back(in_data_i);
      tick();
    end
    in_valid_i = 1'b0;
    check("pp_count_before", fifo_count_o, 3);
    read_flicker_i = 1'b1;
    for (int g = 0; g < 10 && busy_o === 1'b1; g++) tick();
    check("pp_idle", busy_o, 0);
    in_valid_i = 1'b1; in_data_i = 8'h14; exp_q.push_back(8'h14);
    tick();
    in_valid_i = 1'b0;
    check("pp_count_same", fifo_count_o, 3);
    check("pp_popped", data_o, 8'h11);
    run_random(15, 2000);
    check_order("wrap");

    // Timeout after 16 WAIT_ACK cycles, late ack, clear; then set beating a held clear.
    do_reset(1'b0);
    in_valid_i = 1'b1; in_data_i = 8'h77;
    tick();
    in_valid_i = 1'b0;
    tick(); tick();
    check("to_wf", write_flicker_o, 1);
    repeat (15) tick();
    check("to_before", timeout_o, 0);
    tick();
    check("to_set", timeout_o, 1);
    check("to_busy", busy_o, 1);
    repeat (10) tick();
    check("to_keeps_waiting", busy_o, 1);
    read_flicker_i = 1'b1;
    for (int g = 0; g < 10 && busy_o === 1'b1; g++) tick();
    check("to_late_ack", busy_o, 0);
    check("to_data", data_o, 8'h77);
    check("to_sticky", timeout_o, 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("to_cleared", timeout_o, 0);
    clear_i = 1'b1; in_valid_i = 1'b1; in_data_i = 8'h78;
    tick();
    in_valid_i = 1'b0;
    tick(); tick();
    check("to2_wf", write_flicker_o, 0);
    repeat (15) tick();
    check("to2_before", timeout_o, 0);
    tick();
    check("to2_set_wins", timeout_o, 1);
    tick();
    check("to2_clear_after", timeout_o, 0);
    clear_i = 1'b0; read_flicker_i = 1'b0;
    for (int g = 0; g < 10 && busy_o === 1'b1; g++) tick();
    check("to2_done", busy_o, 0);
    check("to_toggles", toggles, 2);

    // Peer ack stuck high out of reset blocks the transfer until it returns low.
    do_reset(1'b1);
    check("ds_reset", desync_o, 0);
    check("ds_reset_ready", in_ready_o, 1);
    tick(); tick();
    check("ds_high", desync_o, 1);
    in_valid_i = 1'b1; in_data_i = 8'h3C;
    tick();
    in_valid_i = 1'b0;
    repeat (5) tick();
    check("ds_no_busy", busy_o, 0);
    check("ds_no_toggle", toggles, 0);
    check("ds_queued", fifo_count_o, 1);
    read_flicker_i = 1'b0;
    tick(); tick();
    check("ds_resync", desync_o, 0);
    tick();
    check("ds_started", busy_o, 1);
    check("ds_data", data_o, 8'h3C);
    exp_q.push_back(8'h3C);
    run_random(0, 200);
    check_order("ds");

    // Reset while waiting for an ack with four bytes still queued.
    do_reset(1'b0);
    in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data_i = 8'(8'h50 + i);
      tick();
    end
    in_valid_i = 1'b0;
    check("rw_count", fifo_count_o, 4);
    check("rw_busy", busy_o, 1);
    check("rw_wf", write_flicker_o, 1);
    reset_i = 1'b1;
    tick();
    toggles = 0;
    check("rw_data", data_o, 0);
    check("rw_wf0", write_flicker_o, 0);
    check("rw_busy0", busy_o, 0);
    check("rw_count0", fifo_count_o, 0);
    check("rw_ready", in_ready_o, 1);
    check("rw_desync", desync_o, 0);
    check("rw_timeout", timeout_o, 0);
    reset_i = 1'b0;
    repeat (10) tick();
    check("rw_no_toggle", toggles, 0);
    check("rw_still_empty", fifo_count_o, 0);
    check("rw_still_idle", busy_o, 0);

    // Randomized traffic against the in-order queue model.
    do_reset(1'b0);
    run_random(60, 3000);
    check_order("rand");
    check("rand_no_timeout", timeout_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flicker_channel_tx.md
FLICKER_CHANNEL_TX -- requirements
Module: flicker_channel_tx

Interface
REQ-001 Parameter pDEPTH, default 8: byte FIFO depth, a power of two, 2..64.
REQ-002 Parameter pSYNC_STAGES, default 2: number of flops synchronizing read_flicker_i.
REQ-003 Parameter pTIMEOUT, default 1048575: WAIT_ACK cycle limit; 0 disables the timeout.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 in_data_i  in  8  byte to transmit.
REQ-007 in_valid_i  in  1  in_data_i is valid.
REQ-008 in_ready_o  out  1  FIFO can accept a byte.
REQ-009 data_o  out  8  byte presented to the peer (GPIO/register side).
REQ-010 write_flicker_o  out  1  toggles once per byte presented.
REQ-011 read_flicker_i  in  1  peer ack toggle; may be asynchronous.
REQ-012 clear_i  in  1  clears the sticky timeout_o.
REQ-013 busy_o  out  1  high in the SETUP and WAIT_ACK states.
REQ-014 fifo_count_o  out  $clog2(pDEPTH)+1  current FIFO occupancy.
REQ-015 timeout_o  out  1  sticky flag: ack wait exceeded pTIMEOUT.
REQ-016 desync_o  out  1  in IDLE, synced read flicker differs from write_flicker_o.

Function
REQ-017 The FIFO SHALL accept a byte on any edge where in_valid_i and in_ready_o are both high; in_ready_o = (fifo_count_o < pDEPTH), with no bypass path.
REQ-018 On a simultaneous push and pop, fifo_count_o SHALL remain unchanged; pointers SHALL wrap modulo pDEPTH.
REQ-019 The FSM SHALL have exactly three states: IDLE, SETUP, WAIT_ACK.
REQ-020 IDLE -> SETUP when the FIFO is non-empty and the synced ack equals write_flicker_o; on that edge the FSM pops the head byte into data_o.
REQ-021 SETUP -> WAIT_ACK unconditionally; on that edge write_flicker_o inverts, giving data one cycle of setup before the toggle.
REQ-022 WAIT_ACK -> IDLE on the first edge where the synced ack equals write_flicker_o.
REQ-023 data_o SHALL hold stable from the pop edge until the next pop.
REQ-024 Latency: for a byte accepted at edge k with the FSM idle and the FIFO empty, data_o updates at edge k+1 and write_flicker_o toggles at edge k+2.
REQ-025 The ack SHALL pass through pSYNC_STAGES flops reset to 0; the raw read_flicker_i SHALL never be used directly.
REQ-026 Back-to-back: with a non-empty FIFO, the next pop SHALL occur on the edge after the WAIT_ACK -> IDLE edge.
REQ-027 The timeout counter SHALL clear on entry to WAIT_ACK and increment each WAIT_ACK cycle, saturating.
REQ-028 When the counter reaches pTIMEOUT (pTIMEOUT > 0), timeout_o SHALL be set, and the FSM keeps waiting.
REQ-029 clear_i SHALL clear timeout_o; if clear_i coincides with a set event, the set wins.
REQ-030 While desync_o is high, no transfer SHALL start; desync_o = (state == IDLE) and (synced ack != write_flicker_o).
REQ-031 Pushes during SETUP and WAIT_ACK SHALL be accepted normally.

Reset
REQ-032 When reset_i is high at an edge, state = IDLE, the FIFO is empty, and fifo_count_o = 0.
REQ-033 When reset_i is high at an edge, data_o = 0, write_flicker_o = 0, the sync flops = 0, and timeout_o = 0.
REQ-034 Out of reset, in_ready_o = 1, busy_o = 0, and desync_o = 0.
REQ-035 A reset mid-transfer SHALL drop the in-flight byte and all queued bytes without emitting a further toggle.

Structure
REQ-036 A shared package flicker_channel_pkg SHALL hold the state enum (IDLE, SETUP, WAIT_ACK) and the default pDEPTH, pSYNC_STAGES and pTIMEOUT constants.
REQ-037 The FIFO SHALL be one sub-module, flicker_tx_fifo (synchronous, registered count, no fall-through); the synchronizer and FSM remain in flicker_channel_tx.

Verification
REQ-038 Single byte: push 0xA5 at edge k, ack after 5 cycles -> data_o = 0xA5 at k+1, write_flicker_o 0->1 at k+2, busy_o low 1+pSYNC_STAGES edges after the ack.
REQ-039 Burst with pDEPTH = 8: push 9 bytes 0x00..0x08 with no acks -> in_ready_o low after the 8 entries are in, then the 9th is accepted after the first pop; all 9 are delivered in order with 9 toggles.
REQ-040 Simultaneous push/pop at count 3 -> count stays 3; pointers wrap cleanly over 20 bytes.
REQ-041 Timeout with pTIMEOUT = 16 and no ack -> timeout_o rises after 16 WAIT_ACK cycles; a late ack still completes the byte; clear_i then drops timeout_o.
REQ-042 Desync: hold read_flicker_i = 1 out of reset and push 0x3C -> desync_o = 1 and no toggle; drive read_flicker_i to 0 -> the transfer proceeds.
REQ-043 Reset in WAIT_ACK with 4 bytes queued -> all outputs reach reset values the next edge and no further toggles occur.
